bmp_reader: RTL
===============

# bmp_reader

Reads a 24-bit uncompressed BMP image held in a byte-wide on-chip memory and streams its pixels out over a valid/ready interface. It parses and validates the 54-byte header, then walks the pixel array row by row, skipping 4-byte row padding. It is the consumer-side counterpart of the crop block's BMP writer: it feeds the crop datapath or an on-chip checker from the same byte-image format the crop block emits.

## Interface

Parameters:
- ADDR_W, 15: byte-address width of the image memory (32768 bytes).
- DIM_W, 12: width of the x/y and dimension fields; the maximum width or height is 2^DIM_W-1.

Ports:
- CLOCK_50  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; driven from KEY[3] at top level.
- start  in  1  single-cycle request to parse from address 0.
- mem_addr  out  ADDR_W  byte read address.
- mem_rdata  in  8  read data; synchronous memory, valid exactly 1 cycle after mem_addr.
- img_w, img_h  out  DIM_W  parsed dimensions; valid from the cycle px_valid first rises until the next start.
- px_valid  out  1  pixel available.
- px_ready  in  1  consumer accepts the pixel when px_valid && px_ready.
- px_rgb  out  24  {R,G,B}.
- px_x, px_y  out  DIM_W  pixel coordinates (BMP orientation, y=0 is the bottom row).
- px_eol  out  1  px_x == img_w-1.
- px_last  out  1  final pixel of the image.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  high in DONE until the next start or reset.
- err  out  1  high in ERR until the next start or reset.

## Operation

- States: IDLE, HDR, CHECK, FETCH, PRESENT, PAD, DONE, ERR.
- Reset: state IDLE; every output, including mem_addr, is 0.
- start is honoured in IDLE, DONE and ERR. It clears done and err and enters HDR. It is ignored while busy.
- HDR: issue addresses 0..53 on consecutive cycles and capture the bytes little-endian: magic bytes 0–1, pixel offset bytes 10–13, width bytes 18–21, height bytes 22–25, bpp bytes 28–29.
- CHECK goes to ERR if any of these holds:
  - magic is not 0x42,0x4D;
  - bpp is not 24;
  - width or height is 0, or either value is at least 2^DIM_W (this covers negative height);
  - offset bits above ADDR_W are non-zero.
- Otherwise CHECK goes to FETCH with addr = offset, x = 0, y = 0, and pad = (4 - (3*img_w mod 4)) mod 4.
- FETCH: read B, G, R at addr, addr+1, addr+2 (on-disk order), then go to PRESENT.
- PRESENT: hold px_valid with stable fields until px_ready. On the handshake:
  - if px_last, go to DONE;
  - else if px_eol, go to PAD;
  - else go to FETCH.
- PAD: advance addr by pad with no memory reads. Set x = 0, increment y, then go to FETCH. Takes 1 cycle even when pad is 0.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is not an error.

## Timing

- Take start in cycle 0. Addresses 0..53 are driven in cycles 1..54, and the last header byte arrives in cycle 55.
- CHECK occurs in cycle 56. err or FETCH begins in cycle 57.
- FETCH takes 4 cycles: 3 addresses, plus 1 cycle of read latency. px_valid rises in the cycle after the R byte arrives, so the first px_valid is in cycle 61.
- With px_ready held high, each pixel takes 5 cycles (4 FETCH + 1 PRESENT). Each row adds 1 PAD cycle.
- px_valid never drops without a handshake, and the fields do not change while it is high.
- Reset asserted mid-operation returns the block to IDLE immediately. Reads in flight are discarded.

## Structure

- Package bmp_pkg holds:
  - header byte offsets (BMP_MAGIC_OFS=0, BMP_OFFSET_OFS=10, BMP_WIDTH_OFS=18, BMP_HEIGHT_OFS=22, BMP_BPP_OFS=28);
  - BMP_HDR_BYTES=54;
  - the state enum;
  - the pixel struct {r,g,b}.
- The crop writer's header generator uses the same constants.
- Sub-module bmp_hdr_parse contains the HDR capture and CHECK logic and outputs width, height, offset, pad and a bad flag.

## Test plan

- 2x2 image, offset 54, pixel bytes 01 02 03 04 05 06 00 00 07 08 09 0A 0B 0C 00 00, px_ready=1. Required: pixels 0x030201@(0,0), 0x060504@(1,0, eol), 0x090807@(0,1), 0x0C0B0A@(1,1, eol, last). done rises 1 cycle after the last handshake. Addresses 60–61 are never read.
- Magic 'B','N'. Required: err=1 from cycle 57; px_valid is never high; busy=0.
- bpp=32, and separately height=0xFFFFFFFE (negative). Required: err in both cases.
- 3x1 image (pad 3) with px_ready toggled every other cycle. Required: 3 pixels with fields stable while stalled, and no duplicate or dropped pixel.
- Reset pulsed during FETCH of pixel 1. Required: all outputs 0. A following start re-emits pixel (0,0) first.
- start pulsed while busy. Required: ignored and the stream is unchanged. start in DONE. Required: the full stream is repeated.

Source files
------------

// File: rtl/bmp_pkg.sv
// bmp_pkg: shared BMP header layout, reader FSM states and pixel type.
// The same header offsets are used by the crop block's BMP header generator.
package bmp_pkg;
    localparam int BMP_MAGIC_OFS  = 0;
    localparam int BMP_OFFSET_OFS = 10;
    localparam int BMP_WIDTH_OFS  = 18;
    localparam int BMP_HEIGHT_OFS = 22;
    localparam int BMP_BPP_OFS    = 28;
    localparam int BMP_HDR_BYTES  = 54;

    // "BM" as it appears when bytes 0..1 are read little-endian
    localparam logic [15:0] BMP_MAGIC = 16'h4D42;
    localparam logic [15:0] BMP_BPP24 = 16'd24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_CHECK   = 3'd2,
        ST_FETCH   = 3'd3,
        ST_PRESENT = 3'd4,
        ST_PAD     = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;
endpackage

// File: rtl/bmp_hdr_parse.sv
// bmp_hdr_parse: captures the BMP header fields and judges whether the image is readable.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear       restart capture (new parse request)
//   cap, idx    a header byte at address idx is present on rdata
//   rdata       header byte
//   width, height, offset  parsed fields, truncated to the reader's widths
//   pad         row padding in bytes
//   bad         header is malformed or exceeds the reader's limits
module bmp_hdr_parse
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cap,
    input  logic [5:0]        idx,
    input  logic [7:0]        rdata,
    output logic [DIM_W-1:0]  width,
    output logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] offset,
    output logic [1:0]        pad,
    output logic              bad
);
    logic [15:0] magic;
    logic [15:0] bpp;
    logic [31:0] ofs_raw;
    logic [31:0] w_raw;
    logic [31:0] h_raw;
    logic [5:0]  rel_mag;
    logic [5:0]  rel_ofs;
    logic [5:0]  rel_w;
    logic [5:0]  rel_h;
    logic [5:0]  rel_bpp;

    // byte position relative to each field; out-of-field positions wrap to large values
    assign rel_mag = idx - 6'(BMP_MAGIC_OFS);
    assign rel_ofs = idx - 6'(BMP_OFFSET_OFS);
    assign rel_w   = idx - 6'(BMP_WIDTH_OFS);
    assign rel_h   = idx - 6'(BMP_HEIGHT_OFS);
    assign rel_bpp = idx - 6'(BMP_BPP_OFS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            magic   <= '0;
            bpp     <= '0;
            ofs_raw <= '0;
            w_raw   <= '0;
            h_raw   <= '0;
        end else if (clear) begin
            magic   <= '0;
            bpp     <= '0;
            ofs_raw <= '0;
            w_raw   <= '0;
            h_raw   <= '0;
        end else if (cap) begin
            if (rel_mag < 6'd2) magic[{rel_mag[0], 3'b000} +: 8] <= rdata;
            if (rel_bpp < 6'd2) bpp[{rel_bpp[0], 3'b000} +: 8] <= rdata;
            if (rel_ofs < 6'd4) ofs_raw[{rel_ofs[1:0], 3'b000} +: 8] <= rdata;
            if (rel_w < 6'd4) w_raw[{rel_w[1:0], 3'b000} +: 8] <= rdata;
            if (rel_h < 6'd4) h_raw[{rel_h[1:0], 3'b000} +: 8] <= rdata;
        end
    end

    assign width  = w_raw[DIM_W-1:0];
    assign height = h_raw[DIM_W-1:0];
    assign offset = ofs_raw[ADDR_W-1:0];
    // (4 - 3w mod 4) mod 4 reduces to w mod 4
    assign pad    = w_raw[1:0];
    // upper-bit checks also reject negative (top-down) heights
    assign bad    = (magic != BMP_MAGIC) || (bpp != BMP_BPP24) ||
                    (w_raw == '0) || (h_raw == '0) ||
                    (|w_raw[31:DIM_W]) || (|h_raw[31:DIM_W]) ||
                    (|ofs_raw[31:ADDR_W]);
endmodule

// File: rtl/bmp_reader.sv
// bmp_reader: parses a 24-bit BMP from byte memory and streams its pixels over valid/ready.
// Ports:
//   CLOCK_50, rst_n      clock, async active-low reset
//   start                parse request (honoured only when not busy)
//   mem_addr, mem_rdata  synchronous byte memory, 1-cycle read latency
//   img_w, img_h         parsed dimensions
//   px_valid, px_ready   pixel handshake
//   px_rgb, px_x, px_y   pixel colour {R,G,B} and coordinates (y=0 is bottom row)
//   px_eol, px_last      end of row, final pixel
//   busy, done, err      status
module bmp_reader
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DIM_W  = 12
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [DIM_W-1:0]  img_w,
    output logic [DIM_W-1:0]  img_h,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [23:0]       px_rgb,
    output logic [DIM_W-1:0]  px_x,
    output logic [DIM_W-1:0]  px_y,
    output logic              px_eol,
    output logic              px_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state;
    logic [5:0]        cnt;
    pixel_t            pix;
    logic [ADDR_W-1:0] offset;
    logic [1:0]        pad;
    logic              bad;
    logic              go;
    logic              hdr_cap;

    assign busy     = !(state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign go       = start && !busy;
    assign done     = state == ST_DONE;
    assign err      = state == ST_ERR;
    assign px_valid = state == ST_PRESENT;
    assign px_rgb   = pix;
    assign px_eol   = px_valid && (px_x == img_w - DIM_W'(1));
    assign px_last  = px_eol && (px_y == img_h - DIM_W'(1));
    // byte for address cnt-1 arrives while cnt is on the bus
    assign hdr_cap  = (state == ST_HDR) && (cnt != 6'd0);

    bmp_hdr_parse #(
        .ADDR_W(ADDR_W),
        .DIM_W (DIM_W)
    ) u_hdr (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .clear (go),
        .cap   (hdr_cap),
        .idx   (cnt - 6'd1),
        .rdata (mem_rdata),
        .width (img_w),
        .height(img_h),
        .offset(offset),
        .pad   (pad),
        .bad   (bad)
    );

    // mem_addr only ever points at header or pixel bytes, never at row padding
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mem_addr <= '0;
            px_x     <= '0;
            px_y     <= '0;
            pix      <= '0;
        end else if (go) begin
            state    <= ST_HDR;
            cnt      <= '0;
            mem_addr <= '0;
            px_x     <= '0;
            px_y     <= '0;
        end else begin
            case (state)
                ST_HDR: begin
                    cnt <= cnt + 6'd1;
                    if (cnt < 6'(BMP_HDR_BYTES - 1)) mem_addr <= mem_addr + ADDR_W'(1);
                    if (cnt == 6'(BMP_HDR_BYTES)) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    state    <= bad ? ST_ERR : ST_FETCH;
                    mem_addr <= offset;
                    cnt      <= '0;
                end
                ST_FETCH: begin
                    cnt <= cnt + 6'd1;
                    if (cnt < 6'd2) mem_addr <= mem_addr + ADDR_W'(1);
                    if (cnt == 6'd1) pix.b <= mem_rdata;
                    if (cnt == 6'd2) pix.g <= mem_rdata;
                    if (cnt == 6'd3) begin
                        pix.r <= mem_rdata;
                        state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (px_ready) begin
                        cnt <= '0;
                        if (px_last) begin
                            state <= ST_DONE;
                        end else if (px_eol) begin
                            state <= ST_PAD;
                        end else begin
                            state    <= ST_FETCH;
                            px_x     <= px_x + DIM_W'(1);
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_PAD: begin
                    state    <= ST_FETCH;
                    px_x     <= '0;
                    px_y     <= px_y + DIM_W'(1);
                    mem_addr <= mem_addr + ADDR_W'(pad) + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
